// File: rtl/neuron_phase_loader_if.sv
// Phase write port for neuron_phase_loader: the host writes one phase per neuron
// while the loader is not shifting.
interface neuron_phase_loader_if #(
    parameter int N_NEURONS = 15,
    parameter int PHI_W     = 4
) ();
    localparam int IDX_W = $clog2(N_NEURONS);

    logic             wr_valid;
    logic [IDX_W-1:0] wr_idx;
    logic [PHI_W-1:0] wr_data;
    logic             wr_ready;

    modport master (output wr_valid, wr_idx, wr_data, input wr_ready);
    modport slave  (input wr_valid, wr_idx, wr_data, output wr_ready);
endinterface

// File: rtl/neuron_phase_loader.sv
// Serial loader for the neuron phase chain: stores one phase per neuron and streams
// them MSB-first (last neuron first) with a divided shift strobe. LOADER_READBACK_EN adds chain readback.
module neuron_phase_loader #(
    parameter int N_NEURONS = 15,
    parameter int PHI_W     = 4,
    parameter int SHIFT_DIV = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    neuron_phase_loader_if.slave         wr,
    input  logic                         start,
    output logic                         ser_out,
    output logic                         shift_en,
    input  logic                         ser_in,
    output logic                         busy,
    output logic                         done,
    input  logic [$clog2(N_NEURONS)-1:0] rd_idx,
    output logic [PHI_W-1:0]             rd_data
);
    localparam int IDX_W = $clog2(N_NEURONS);
    localparam int TOTAL = N_NEURONS * PHI_W;
    localparam int CNT_W = $clog2(TOTAL);
    localparam int DIV_W = $clog2(SHIFT_DIV);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TOTAL - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SHIFT_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e                              state_q, state_d;
    logic [N_NEURONS-1:0][PHI_W-1:0]     mem_q, mem_d;
    logic [TOTAL-1:0]                    sr_q, sr_d;
    logic [CNT_W-1:0]                    cnt_q, cnt_d;
    logic [DIV_W-1:0]                    div_q, div_d;
    logic                                ser_out_q, ser_out_d;
    logic                                shift_en_q, shift_en_d;
    logic                                busy_q, busy_d;
    logic                                done_q, done_d;
    logic                                wr_ready_q, wr_ready_d;
    logic                                wr_fire;
`ifdef LOADER_READBACK_EN
    logic [TOTAL-1:0]                    rb_q, rb_d;
    logic [N_NEURONS-1:0][PHI_W-1:0]     rb_view;
`endif

    assign wr_fire = wr.wr_valid && wr_ready_q;

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
`ifdef LOADER_READBACK_EN
        rb_d    = rb_q;
`endif
        if (state_q == SHIFT) begin
            // shift_en_q high means the chain is taking the current bit this cycle
            if (shift_en_q) begin
                sr_d  = sr_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
`ifdef LOADER_READBACK_EN
                rb_d  = {rb_q[TOTAL-2:0], ser_in};
`endif
                if (cnt_q == LAST_BIT) state_d = DONE;
            end
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end else begin
            if (wr_fire) begin
                if ({1'b0, wr.wr_idx} < (IDX_W+1)'(N_NEURONS)) mem_d[wr.wr_idx] = wr.wr_data;
                if (state_q == DONE) state_d = IDLE;
            end
            // load from mem_d so a same-cycle write lands in the stream
            if (start) begin
                state_d = SHIFT;
                sr_d    = mem_d;
                cnt_d   = '0;
                div_d   = '0;
`ifdef LOADER_READBACK_EN
                rb_d    = '0;
`endif
            end
        end
        busy_d     = (state_d == SHIFT);
        done_d     = (state_d == DONE);
        wr_ready_d = (state_d != SHIFT);
        shift_en_d = (state_d == SHIFT) && (div_d == DIV_LAST);
        ser_out_d  = (state_d == SHIFT) && sr_d[TOTAL-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mem_q      <= '0;
            sr_q       <= '0;
            cnt_q      <= '0;
            div_q      <= '0;
            ser_out_q  <= 1'b0;
            shift_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ready_q <= 1'b1;
`ifdef LOADER_READBACK_EN
            rb_q       <= '0;
`endif
        end else begin
            state_q    <= state_d;
            mem_q      <= mem_d;
            sr_q       <= sr_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            ser_out_q  <= ser_out_d;
            shift_en_q <= shift_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_ready_q <= wr_ready_d;
`ifdef LOADER_READBACK_EN
            rb_q       <= rb_d;
`endif
        end
    end

    assign ser_out     = ser_out_q;
    assign shift_en    = shift_en_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign wr.wr_ready = wr_ready_q;

`ifdef LOADER_READBACK_EN
    // rb holds the chain's old contents in the same neuron order as the stream
    assign rb_view = rb_q;
    always_comb begin
        rd_data = '0;
        if ({1'b0, rd_idx} < (IDX_W+1)'(N_NEURONS)) rd_data = rb_view[rd_idx];
    end
`else
    logic unused_rb;
    assign unused_rb = ^{ser_in, rd_idx};
    assign rd_data   = '0;
`endif
endmodule

// File: tb/tb_neuron_phase_loader.sv
// Scoreboard bench for neuron_phase_loader: loads push expected strobe bits/times,
// a monitor pops them on every shift_en; a 15x4 chain model checks final neuron contents.
module tb_neuron_phase_loader;
    localparam int N   = 15;
    localparam int W   = 4;
    localparam int TOT = N * W;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ser_in;
    logic       ser_out, shift_en, busy, done;
    logic [3:0] rd_idx = '0;
    logic [3:0] rd_data;

    always #5 clk = ~clk;

    neuron_phase_loader_if #(.N_NEURONS(N), .PHI_W(W)) wif ();

    neuron_phase_loader #(.N_NEURONS(N), .PHI_W(W), .SHIFT_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wif), .start(start), .ser_out(ser_out),
        .shift_en(shift_en), .ser_in(ser_in), .busy(busy), .done(done),
        .rd_idx(rd_idx), .rd_data(rd_data)
    );

    typedef struct packed { logic b; int cyc; } exp_t;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         n_strobe = 0;
    int         strobe_base = 0;
    exp_t       exp_q[$];
    int         done_q[$];
    exp_t       mon_e;
    logic       done_prev = 1'b0;
    logic [3:0] exp_mem [N];
    logic [TOT-1:0] chain = '0;
    logic [TOT-1:0] preload_val = '0;
    logic       preload = 1'b0;

    assign ser_in = chain[TOT-1];

    // Chain model: head takes ser_out on each strobe, neuron j = chain[4j+3:4j]
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (preload) chain <= preload_val;
        else if (shift_en) chain <= {chain[TOT-2:0], ser_out};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && shift_en) begin
            n_strobe++;
            chk("strobe_expected", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("ser_bit", 32'(ser_out), 32'(mon_e.b));
                chk("strobe_cycle", cyc, mon_e.cyc);
            end
        end
        if (rst_n && !busy) chk("ser_out_idle", 32'(ser_out), 0);
        if (done && !done_prev) begin
            chk("done_expected", 32'(done_q.size() > 0), 1);
            if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
        end
        done_prev = done;
    end

    task automatic wr(input int idx, input int data);
        @(negedge clk);
        wif.wr_valid = 1'b1;
        wif.wr_idx   = idx[3:0];
        wif.wr_data  = data[3:0];
        if (idx < N) exp_mem[idx] = data[3:0];
        @(posedge clk);
        #1 wif.wr_valid = 1'b0;
    endtask

    task automatic load_start();
        int ns;
        @(negedge clk);
        start = 1'b1;
        ns = cyc + 1;
        for (int k = 0; k < TOT; k++)
            exp_q.push_back('{b: exp_mem[N-1-k/W][W-1-k%W], cyc: ns + 4*k + 3});
        done_q.push_back(ns + 240);
        strobe_base = n_strobe;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int got = 0;
        for (int i = 0; i < 400 && got == 0; i++) begin
            @(negedge clk);
            if (done) got = 1;
        end
        chk("done_reached", got, 1);
    endtask

    task automatic check_chain(input string tag);
        for (int j = 0; j < N; j++) chk(tag, 32'(chain[j*W +: W]), 32'(exp_mem[j]));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) exp_mem[j] = '0;
    endtask

    initial begin
        int hi;
        int cnt;
        wif.wr_valid = 1'b0;
        wif.wr_idx   = '0;
        wif.wr_data  = '0;
        for (int j = 0; j < N; j++) exp_mem[j] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // reset state after idling
        repeat (10) @(negedge clk);
        chk("rst_ser_out", 32'(ser_out), 0);
        chk("rst_shift_en", 32'(shift_en), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_wr_ready", 32'(wif.wr_ready), 1);
        chk("rst_rd_data", 32'(rd_data), 0);

        // phase[j] = j, full load
        for (int j = 0; j < N; j++) wr(j, j);
        load_start();
        @(negedge clk);
        chk("busy_after_start", 32'(busy), 1);
        chk("wr_ready_after_start", 32'(wif.wr_ready), 0);
        chk("first_bit", 32'(ser_out), 1);
        wait_done();
        chk("strobe_count_1", n_strobe - strobe_base, 60);
        check_chain("chain_load1");
        chk("chain_n14", 32'(chain[59:56]), 14);
        chk("busy_in_done", 32'(busy), 0);

        // second load from DONE with start re-pulsed and a write held mid-shift
        load_start();
        repeat (40) @(negedge clk);
        start = 1'b1;
        wif.wr_valid = 1'b1;
        wif.wr_idx   = 4'd0;
        wif.wr_data  = 4'hA;
        @(negedge clk);
        start = 1'b0;
        hi = 0;
        repeat (100) begin
            @(negedge clk);
            if (wif.wr_ready) hi++;
        end
        chk("wr_ready_in_shift", hi, 0);
        wif.wr_valid = 1'b0;
        wait_done();
        chk("strobe_count_2", n_strobe - strobe_base, 60);
        check_chain("chain_load2");
        repeat (5) @(negedge clk);
        chk("done_holds", 32'(done), 1);

        // write in DONE (dropped index) returns to IDLE
        wr(15, 15);
        @(negedge clk);
        chk("done_cleared_by_write", 32'(done), 0);
        chk("wr_ready_idle", 32'(wif.wr_ready), 1);

        // out-of-range write after reset is dropped
        do_reset();
        wr(15, 15);
        load_start();
        wait_done();
        chk("strobe_count_3", n_strobe - strobe_base, 60);
        check_chain("chain_drop");

        // reset at strobe 30 aborts the load and clears the store
        for (int j = 0; j < N; j++) wr(j, 9);
        load_start();
        cnt = 0;
        for (int i = 0; i < 300 && cnt < 30; i++) begin
            @(negedge clk);
            #1;
            if (shift_en) cnt++;
        end
        chk("reached_strobe_30", cnt, 30);
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) exp_mem[j] = '0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_shift_en", 32'(shift_en), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_wr_ready", 32'(wif.wr_ready), 1);
        repeat (20) @(negedge clk);
        chk("abort_strobes", n_strobe - strobe_base, 30);
        load_start();
        wait_done();
        chk("strobe_count_4", n_strobe - strobe_base, 60);
        check_chain("chain_after_abort");

`ifdef LOADER_READBACK_EN
        // chain preloaded with neuron j = 15-j, then loaded with all 0x5
        @(negedge clk);
        for (int j = 0; j < N; j++) preload_val[j*W +: W] = 4'(15 - j);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
        for (int j = 0; j < N; j++) wr(j, 5);
        load_start();
        wait_done();
        check_chain("chain_rb");
        rd_idx = 4'd3;
        #1 chk("rd_idx3", 32'(rd_data), 12);
        rd_idx = 4'd14;
        #1 chk("rd_idx14", 32'(rd_data), 1);
        rd_idx = 4'd0;
        #1 chk("rd_idx0", 32'(rd_data), 15);
        rd_idx = 4'd15;
        #1 chk("rd_idx15", 32'(rd_data), 0);
`endif

        repeat (5) @(negedge clk);
        chk("no_pending_strobes", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/neuron_phase_loader.md
# neuron_phase_loader

Serial loader for the oscillatory neuron array's phase chain. It accepts one initial phase per neuron over a parallel write port. On `start`, it serializes all phases onto the daisy-chained `ser_state_in` input of the neuron bank, together with a one-cycle shift strobe, so that after the last strobe neuron *j* holds phase *j*. It sits between the host/pattern controller and the 3x5 neuron bank, on the driving end of the bank's serial state chain.

## Interface
- `N_NEURONS`, 15, number of neurons in the chain
- `PHI_W`, 4, phase width in bits per neuron
- `SHIFT_DIV`, 4, clocks per serial bit (≥2); one `shift_en` pulse per bit
- `clk` input 1 system clock, all logic on rising edge
- `rst_n` input 1 reset; one clock, synchronous, active-low
- `wr_valid` input 1 phase write request
- `wr_idx` input $clog2(N_NEURONS) target neuron index
- `wr_data` input PHI_W phase value
- `wr_ready` output 1 write accepted when `wr_valid && wr_ready`
- `start` input 1 begin serial load (single-cycle pulse or level)
- `ser_out` output 1 serial data, drives the bank's `ser_state_in`
- `shift_en` output 1 one-cycle strobe; the chain shifts `ser_out` in on this cycle
- `ser_in` input 1 tail of chain (last neuron's `ser_state_out`); used only with readback
- `busy` output 1 high during SHIFT
- `done` output 1 high in DONE
- `rd_idx` input $clog2(N_NEURONS) readback index (readback build only)
- `rd_data` output PHI_W readback phase (readback build only)

## Operation
- Phase store: `phase_mem[N_NEURONS]` of PHI_W bits, cleared to 0 on reset.
- States: IDLE, SHIFT, DONE. Reset enters IDLE.
- IDLE/DONE: `wr_ready`=1. An accepted write sets `phase_mem[wr_idx]`=`wr_data`. `wr_idx` ≥ N_NEURONS is accepted and dropped. A write in DONE returns to IDLE.
- `start` sampled high in IDLE or DONE → SHIFT. The 60-bit shift register (N_NEURONS*PHI_W) loads from `phase_mem` on that edge. The bit counter and divider counter clear to 0.
- If a write and `start` occur in the same cycle, the write is committed first. The new value is included in the load.
- Stream order: bit k (k=0..N*PHI_W-1) = `phase_mem[N-1-k/PHI_W][PHI_W-1-k%PHI_W]`, i.e. neuron 14 MSB first, neuron 0 LSB last.
- SHIFT: `wr_ready`=0 and `start` is ignored.
  - The divider counts 0..SHIFT_DIV-1.
  - `shift_en`=1 when divider = SHIFT_DIV-1.
  - After each strobe, `ser_out` advances to the next bit.
  - The strobe after the final bit → DONE.
- DONE: `done`=1 and holds until `start` (→SHIFT) or an accepted write (→IDLE).
- `ser_out` is 0 outside SHIFT. `shift_en` is never high outside SHIFT.
- Reset mid-SHIFT aborts the load with no further strobes. All state returns to reset values; the chain is left partially shifted.

## Timing
- Reset values: `wr_ready`=1, `ser_out`=0, `shift_en`=0, `busy`=0, `done`=0, `rd_data`=0. All outputs are registered except `rd_data`.
- `start` sampled at edge t:
  - `busy`=1 and `ser_out`=bit0 from t+1.
  - First `shift_en` at cycle t+SHIFT_DIV.
  - Strobe *m* at t+m·SHIFT_DIV.
  - Last strobe at t+N·PHI_W·SHIFT_DIV (t+240 with defaults).
  - `busy`=0 and `done`=1 at t+240+1.
- `ser_out` is stable for SHIFT_DIV cycles around each strobe. It changes only on the cycle after a strobe.
- Write latency: `phase_mem` updated on the accepting edge, visible to a `start` in the next or the same cycle.

## Configuration
- `LOADER_READBACK_EN` defined:
  - On each `shift_en`, `ser_in` is shifted into a 60-bit readback register, cleared on reset and at `start`.
  - After DONE, `rd_data`=`rb[rd_idx]` (combinational), using the same bit mapping as the stream. This equals the phase neuron `rd_idx` held before the load.
  - `rd_idx` ≥ N_NEURONS returns 0.
- Undefined: the readback register is not built, `ser_in` is ignored, and `rd_data` is tied to 0.

## Test plan
- Reset, then idle 10 cycles → `ser_out`=0, `shift_en`=0, `busy`=0, `done`=0, `wr_ready`=1.
- Write phase[j]=j for j=0..14, pulse `start` → exactly 60 strobes at 4-cycle spacing; first bit = phase[14] bit3 = 1; a 15×4 chain model ends with neuron j = j; `done` at start+241.
- `start` pulsed again mid-SHIFT and `wr_valid` held during SHIFT → strobe count stays 60; `phase_mem` unchanged; `wr_ready`=0 throughout.
- Write idx 15, data 0xF, then load → ignored; all neurons = 0 after load (post-reset store).
- `rst_n` low at strobe 30 → no further strobes; next cycle `busy`=0 and store cleared; a fresh load completes normally.
- `LOADER_READBACK_EN`: preload chain model with neuron j = 15-j, load all 0x5 → `rd_data` for `rd_idx`=3 is 12, `rd_idx`=14 is 1, all neurons 0x5.
